// File: rtl/bcam_pkg.sv
// Shared definitions for the BCAM match encoder: FSM state encoding and default depth.
package bcam_pkg;

  localparam int BCAM_DEPTH_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } bcam_state_e;

endpackage

// File: rtl/bcam_prio_enc.sv
// Combinational lowest-set-bit finder; index 0 has the highest priority.
module bcam_prio_enc
  import bcam_pkg::*;
#(
  parameter int DEPTH  = BCAM_DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  vec_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic              any_o
);

  // Scanning downward lets the lowest set bit win the last assignment.
  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = ADDR_W'(i);
      end
    end
  end

endmodule

// File: rtl/bcam_match_encoder.sv
// Turns a CAM match vector into a stream of matching entry indices.
// Define BCAM_MULTI_MATCH_EN to emit every match; otherwise only the lowest match is reported.
module bcam_match_encoder
  import bcam_pkg::*;
#(
  parameter int DEPTH  = BCAM_DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              match_valid,
  output logic              match_ready,
  input  logic [DEPTH-1:0]  match_vec,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic              last
);

  bcam_state_e       state_q, state_d;
  logic [DEPTH-1:0]  pending_q, pending_d;
  logic              addr_valid_q, addr_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hit_q, hit_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] enc_idx;
  logic              enc_any;
  logic [DEPTH-1:0]  sent_mask;

  // Encoding the next pending value lets the beat outputs come straight from flops.
  bcam_prio_enc #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prio_enc (
    .vec_i (pending_d),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  assign sent_mask = DEPTH'(1) << addr_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      IDLE: begin
        if (match_valid) begin
          pending_d = match_vec;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (addr_ready) begin
          if (last_q) begin
            state_d   = IDLE;
            pending_d = '0;
          end else begin
            pending_d = pending_q & ~sent_mask;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_valid_d = (state_d == EMIT);
    hit_d        = addr_valid_d & enc_any;
    addr_d       = hit_d ? enc_idx : '0;
`ifdef BCAM_MULTI_MATCH_EN
    // A miss is a single terminal beat; otherwise stop when one bit remains.
    last_d = addr_valid_d &
             (!enc_any || ((pending_d & (pending_d - DEPTH'(1))) == '0));
`else
    last_d = addr_valid_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      addr_valid_q <= 1'b0;
      addr_q       <= '0;
      hit_q        <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      addr_valid_q <= addr_valid_d;
      addr_q       <= addr_d;
      hit_q        <= hit_d;
      last_q       <= last_d;
    end
  end

  assign match_ready = (state_q == IDLE) && !rst;
  assign addr_valid  = addr_valid_q;
  assign addr        = addr_q;
  assign hit         = hit_q;
  assign last        = last_q;

endmodule
